// File: rtl/div_seq.sv
// Sequential 4-bit restoring divider: one quotient bit per cycle, result four edges after start.
// Optional build macro: SIGNED_DIV_EN selects two's-complement operands and results.
module div_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       divz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] dvs_q, dvs_d;
    logic [3:0] rem_q, rem_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic [1:0] cnt_q, cnt_d;
    logic       divz_q, divz_d;

    logic [4:0] shift, trial;
    logic [3:0] rem_nx, quo_nx;
    logic [3:0] mag_a, mag_b, q_fin, r_fin;

`ifdef SIGNED_DIV_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
`endif

    // The partial remainder stays below the divisor, so bit 4 of the trial is a clean sign bit.
    always_comb begin
        shift  = {rem_q, quo_q[3]};
        trial  = shift - {1'b0, dvs_q};
        rem_nx = trial[4] ? shift[3:0] : trial[3:0];
        quo_nx = {quo_q[2:0], ~trial[4]};
    end

`ifdef SIGNED_DIV_EN
    // Divide magnitudes; -8 maps to unsigned 8, which still fits four bits.
    always_comb begin
        mag_a = A[3] ? (~A + 4'd1) : A;
        mag_b = B[3] ? (~B + 4'd1) : B;
        q_fin = qneg_q ? (~quo_nx + 4'd1) : quo_nx;
        r_fin = rneg_q ? (~rem_nx + 4'd1) : rem_nx;
    end
`else
    always_comb begin
        mag_a = A;
        mag_b = B;
        q_fin = quo_nx;
        r_fin = rem_nx;
    end
`endif

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        divz_d  = divz_q;
`ifdef SIGNED_DIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (B == 4'd0) begin
                        q_d     = '1;
                        r_d     = A;
                        divz_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = mag_a;
                        dvs_d   = mag_b;
                        rem_d   = '0;
                        cnt_d   = '0;
                        divz_d  = 1'b0;
`ifdef SIGNED_DIV_EN
                        qneg_d  = A[3] ^ B[3];
                        rneg_d  = A[3];
`endif
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    q_d     = q_fin;
                    r_d     = r_fin;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            divz_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            divz_q  <= divz_d;
`ifdef SIGNED_DIV_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign Q    = q_q;
    assign R    = r_q;
    assign divz = divz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq; expected values are hand-computed for the build selected by SIGNED_DIV_EN.
module tb_div_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] A, B;
    logic       busy, done, divz;
    logic [3:0] Q, R;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int overlap = 0;

    div_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Q       (Q),
        .R       (R),
        .divz    (divz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Starts one division; lat = edges after the start edge at which done is seen (-1 if never).
    task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                           output int lat, output int nbusy, output int dcyc);
        lat   = -1;
        nbusy = 0;
        dcyc  = -1;
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                A     = ~a;
                B     = ~b;
            end
            if (busy) nbusy++;
            if (busy && done) overlap++;
            if (done) begin
                lat  = k;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, Q, R, divz} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", {busy, done, Q, R, divz}, 11'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, nb, dc;
        run_div(4'd6, 4'd2, lat, nb, dc);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
        checks++;
        if (nb !== 4) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 4", nb); end
        checks++;
        if ({Q, R, divz} !== {4'd3, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result got Q=%h R=%h divz=%b exp Q=3 R=0 divz=0", Q, R, divz);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] vec [4];
        logic [15:0] v;
        int lat, nb, dc;
`ifdef SIGNED_DIV_EN
        vec = '{16'hD40D, 16'hF1F0, 16'h7710, 16'h0500};
`else
        vec = '{16'hD431, 16'hF1F0, 16'h7710, 16'h0500};
`endif
        foreach (vec[i]) begin
            v = vec[i];
            run_div(v[15:12], v[11:8], lat, nb, dc);
            checks++;
            if ({Q, R} !== v[7:0] || lat !== 4) begin
                errors++;
                $display("FAIL vector_%0d got Q=%h R=%h lat=%0d exp Q=%h R=%h lat=4",
                         i, Q, R, lat, v[7:4], v[3:0]);
            end
        end
    endtask

    task automatic test_divzero();
        int lat, nb, dc;
        run_div(4'd5, 4'd0, lat, nb, dc);
        // done appears in the cycle right after the start edge
        checks++;
        if (lat !== 0 || nb !== 0) begin
            errors++;
            $display("FAIL divz_timing got lat=%0d busy=%0d exp lat=0 busy=0", lat, nb);
        end
        checks++;
        if ({Q, R, divz} !== {4'hF, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL divz_result got Q=%h R=%h divz=%b exp Q=f R=5 divz=1", Q, R, divz);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({Q, R, divz} !== {4'hF, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL divz_hold got Q=%h R=%h divz=%b exp Q=f R=5 divz=1", Q, R, divz);
        end
        run_div(4'd9, 4'd3, lat, nb, dc);
        checks++;
`ifdef SIGNED_DIV_EN
        if ({Q, R, divz} !== {4'hE, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL divz_clear got Q=%h R=%h divz=%b exp Q=e R=f divz=0", Q, R, divz);
        end
`else
        if ({Q, R, divz} !== {4'd3, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL divz_clear got Q=%h R=%h divz=%b exp Q=3 R=0 divz=0", Q, R, divz);
        end
`endif
    endtask

    task automatic test_start_held();
        int k1 = -1, k2 = -1;
        logic b5 = 1'b1, b6 = 1'b0;
        logic [7:0] qr1 = '0, qr2 = '0;
        @(negedge clk);
        start = 1'b1;
        A     = 4'd6;
        B     = 4'd2;
        @(posedge clk);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) begin A = 4'd15; B = 4'd1; end
            if (k == 5) b5 = busy | done;
            if (k == 6) begin b6 = busy; start = 1'b0; end
            if (done && k1 < 0) begin k1 = k; qr1 = {Q, R}; end
            else if (done) begin k2 = k; qr2 = {Q, R}; break; end
        end
        start = 1'b0;
        checks++;
        if (k1 !== 4 || qr1 !== 8'h30) begin
            errors++;
            $display("FAIL held_first got lat=%0d QR=%h exp lat=4 QR=30", k1, qr1);
        end
        checks++;
        if (b5 !== 1'b0 || b6 !== 1'b1) begin
            errors++;
            $display("FAIL held_accept_idle got busy5=%b busy6=%b exp 0 1", b5, b6);
        end
        checks++;
        if (k2 !== 10 || qr2 !== 8'hF0) begin
            errors++;
            $display("FAIL held_second got lat=%0d QR=%h exp lat=10 QR=f0", k2, qr2);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nb, dc;
        int seen = 0;
        @(negedge clk);
        start = 1'b1;
        A     = 4'd7;
        B     = 4'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, Q, R, divz} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b exp %b", {busy, done, Q, R, divz}, 11'd0);
        end
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d exp 0", seen); end
        run_div(4'd8, 4'd3, lat, nb, dc);
        checks++;
`ifdef SIGNED_DIV_EN
        if ({Q, R} !== 8'hEE || lat !== 4) begin
            errors++;
            $display("FAIL reset_mid_after got Q=%h R=%h lat=%0d exp Q=e R=e lat=4", Q, R, lat);
        end
`else
        if ({Q, R} !== 8'h22 || lat !== 4) begin
            errors++;
            $display("FAIL reset_mid_after got Q=%h R=%h lat=%0d exp Q=2 R=2 lat=4", Q, R, lat);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat, nb, d1, d2;
        run_div(4'd7, 4'd2, lat, nb, d1);
        checks++;
        if ({Q, R} !== 8'h31) begin errors++; $display("FAIL b2b_first got QR=%h exp 31", {Q, R}); end
        run_div(4'd6, 4'd4, lat, nb, d2);
        checks++;
        if ({Q, R} !== 8'h12 || (d2 - d1) !== 6) begin
            errors++;
            $display("FAIL b2b_second got QR=%h spacing=%0d exp QR=12 spacing=6", {Q, R}, d2 - d1);
        end
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL busy_done_overlap got %0d exp 0", overlap); end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        int lat, nb, dc;
        run_div(4'b1001, 4'd2, lat, nb, dc);
        checks++;
        if ({Q, R, divz} !== {4'b1101, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL signed_m7_2 got Q=%b R=%b divz=%b exp 1101 1111 0", Q, R, divz);
        end
        run_div(4'b1000, 4'b1111, lat, nb, dc);
        checks++;
        if ({Q, R, divz} !== {4'b1000, 4'b0000, 1'b0} || lat !== 4) begin
            errors++;
            $display("FAIL signed_wrap got Q=%b R=%b divz=%b lat=%0d exp 1000 0000 0 lat=4",
                     Q, R, divz, lat);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_divzero();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
